// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 matrix keypad one column at a time, debounces the
// per-scan result and reports each newly accepted key press exactly once.
// Accepted digits are shifted into a 32-bit history, newest digit in [3:0].
module keypad_scan #(
  parameter int SCAN_DIV       = 16384,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  i_row,
  output logic [3:0]  o_col,
  output logic [3:0]  o_key,
  output logic        o_key_valid,
  output logic        o_key_held,
  output logic [31:0] o_data
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_SCANS);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  // Active-low one-hot column drive for column index c.
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    logic [3:0] drv;
    case (c)
      2'd0:    drv = 4'b1110;
      2'd1:    drv = 4'b1101;
      2'd2:    drv = 4'b1011;
      2'd3:    drv = 4'b0111;
      default: drv = 4'b1111;
    endcase
    return drv;
  endfunction

  // Lowest row pulled low: {found, row[1:0]}; lowest row gives lowest code in a column.
  function automatic logic [2:0] lowest_low_row(input logic [3:0] rows);
    logic [2:0] res;
    casez (rows)
      4'b???0: res = 3'b100;
      4'b??01: res = 3'b101;
      4'b?011: res = 3'b110;
      4'b0111: res = 3'b111;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // Row synchronizer
  logic [3:0]        row_meta_r;
  logic [3:0]        row_sync_r;

  // Column scan
  logic [SLOT_W-1:0] slot_cnt_r;
  logic [1:0]        col_idx_r;
  logic [3:0]        col_r;
  logic              slot_last_s;
  logic              scan_end_s;

  // Candidate and debounce
  logic              acc_found_r;
  logic [3:0]        acc_code_r;
  logic              prev_found_r;
  logic [3:0]        prev_code_r;
  logic [STAB_W-1:0] stab_cnt_r;
  logic              eval_r;
  logic [2:0]        row_hit_s;
  logic              col_hit_s;
  logic [3:0]        col_code_s;
  logic              merge_found_s;
  logic [3:0]        merge_code_s;
  logic              same_s;
  logic [STAB_W-1:0] stab_nxt_s;
  logic              stable_s;

  // FSM and outputs
  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        key_r;
  logic [3:0]        key_nxt_s;
  logic              valid_r;
  logic              valid_nxt_s;
  logic              held_r;
  logic              held_nxt_s;
  logic [31:0]       data_r;
  logic [31:0]       data_nxt_s;

  assign slot_last_s = (slot_cnt_r == SLOT_LAST);
  assign scan_end_s  = slot_last_s && (col_idx_r == 2'd3);
  assign row_hit_s   = lowest_low_row(row_sync_r);
  assign col_hit_s   = row_hit_s[2];
  assign col_code_s  = {row_hit_s[1:0], col_idx_r};
  assign stable_s    = eval_r && (stab_cnt_r == STAB_MAX);

  // Two-flop synchronizer for the asynchronous row inputs; reset to "no key".
  always_ff @(posedge clk) begin
    if (!rstn) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= i_row;
      row_sync_r <= row_meta_r;
    end
  end

  // Slot counter, column index and registered column drive.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      slot_cnt_r <= '0;
      col_idx_r  <= 2'd0;
      col_r      <= 4'b1110;
    end else if (slot_last_s) begin
      slot_cnt_r <= '0;
      col_idx_r  <= col_idx_r + 2'd1;
      col_r      <= col_drive(col_idx_r + 2'd1);
    end else begin
      slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
    end
  end

  // Merge this column's sample into the running lowest-code candidate.
  always_comb begin
    merge_found_s = acc_found_r;
    merge_code_s  = acc_code_r;
    if (col_hit_s && (!acc_found_r || (col_code_s < acc_code_r))) begin
      merge_found_s = 1'b1;
      merge_code_s  = col_code_s;
    end else begin
      merge_found_s = acc_found_r;
      merge_code_s  = acc_code_r;
    end
  end

  // Stability counter update: count up on a repeated candidate, restart at 1 otherwise.
  always_comb begin
    same_s     = (merge_found_s == prev_found_r) && (merge_code_s == prev_code_r);
    stab_nxt_s = STAB_W'(1);
    if (same_s) begin
      if (stab_cnt_r == STAB_MAX) begin
        stab_nxt_s = STAB_MAX;
      end else begin
        stab_nxt_s = stab_cnt_r + STAB_W'(1);
      end
    end else begin
      stab_nxt_s = STAB_W'(1);
    end
  end

  // Per-scan candidate accumulation and end-of-scan debounce registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_found_r  <= 1'b0;
      acc_code_r   <= 4'd0;
      prev_found_r <= 1'b0;
      prev_code_r  <= 4'd0;
      stab_cnt_r   <= '0;
      eval_r       <= 1'b0;
    end else begin
      eval_r <= scan_end_s;
      if (scan_end_s) begin
        acc_found_r  <= 1'b0;
        acc_code_r   <= 4'd0;
        prev_found_r <= merge_found_s;
        prev_code_r  <= merge_code_s;
        stab_cnt_r   <= stab_nxt_s;
      end else if (slot_last_s) begin
        acc_found_r <= merge_found_s;
        acc_code_r  <= merge_code_s;
      end
    end
  end

  // Press/release FSM next state and next output values.
  always_comb begin
    state_nxt_s = state_r;
    key_nxt_s   = key_r;
    valid_nxt_s = 1'b0;
    held_nxt_s  = held_r;
    data_nxt_s  = data_r;
    case (state_r)
      ST_IDLE: begin
        if (stable_s && prev_found_r) begin
          state_nxt_s = ST_PRESSED;
          valid_nxt_s = 1'b1;
          key_nxt_s   = prev_code_r;
          held_nxt_s  = 1'b1;
          data_nxt_s  = {data_r[27:0], prev_code_r};
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        // A stable different code (roll-over) is ignored until a full release.
        if (stable_s && !prev_found_r) begin
          state_nxt_s = ST_IDLE;
          held_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_PRESSED;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        held_nxt_s  = 1'b0;
      end
    endcase
  end

  // FSM state and registered key outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      key_r   <= 4'd0;
      valid_r <= 1'b0;
      held_r  <= 1'b0;
      data_r  <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      key_r   <= key_nxt_s;
      valid_r <= valid_nxt_s;
      held_r  <= held_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  assign o_col       = col_r;
  assign o_key       = key_r;
  assign o_key_valid = valid_r;
  assign o_key_held  = held_r;
  assign o_data      = data_r;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed bench for keypad_scan with a per-scan keypad model.
`timescale 1ns/1ps
module tb_keypad_scan;

  localparam int SD   = 4;
  localparam int DB   = 3;
  localparam int SCAN = 4 * SD;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  i_row;
  logic [3:0]  o_col;
  logic [3:0]  o_key;
  logic        o_key_valid;
  logic        o_key_held;
  logic [31:0] o_data;
  logic [15:0] keys = 16'h0000;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .clk(clk), .rstn(rstn), .i_row(i_row), .o_col(o_col),
    .o_key(o_key), .o_key_valid(o_key_valid), .o_key_held(o_key_held),
    .o_data(o_data)
  );

  always #5 clk = ~clk;

  // Keypad: row r low iff its column is driven low and key 4r+c is closed.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      i_row[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (!o_col[c] && keys[4*r+c]) i_row[r] = 1'b0;
      end
    end
  end

  // Reference model: works per whole scan on the set of closed keys.
  int          tick = 0;
  bit          m_live = 1'b0;
  bit          m_prev_found;
  int          m_prev_code;
  int          m_cnt;
  bit          m_pressed;
  bit          pend_press;
  bit          pend_release;
  int          pend_code;
  logic [3:0]  e_col;
  logic [3:0]  e_key;
  logic        e_valid;
  logic        e_held;
  logic [31:0] e_data;

  always @(posedge clk) begin
    bit found;
    int code;
    if (!rstn) begin
      tick = 0; m_live = 1'b1;
      m_prev_found = 1'b0; m_prev_code = 0; m_cnt = 0; m_pressed = 1'b0;
      pend_press = 1'b0; pend_release = 1'b0; pend_code = 0;
      e_col = 4'b1110; e_key = 4'h0; e_valid = 1'b0; e_held = 1'b0; e_data = 32'h0;
    end else if (m_live) begin
      tick++;
      e_valid = 1'b0;
      if (pend_press) begin
        e_valid = 1'b1; e_key = 4'(pend_code); e_held = 1'b1;
        e_data = {e_data[27:0], 4'(pend_code)};
        pend_press = 1'b0;
      end
      if (pend_release) begin
        e_held = 1'b0; pend_release = 1'b0;
      end
      e_col = 4'b1111;
      e_col[(tick / SD) % 4] = 1'b0;
      if (tick % SCAN == 0) begin
        found = 1'b0; code = 0;
        for (int k = 15; k >= 0; k--) begin
          if (keys[k]) begin found = 1'b1; code = k; end
        end
        if (found == m_prev_found && code == m_prev_code) m_cnt = (m_cnt < DB) ? m_cnt + 1 : DB;
        else m_cnt = 1;
        m_prev_found = found; m_prev_code = code;
        if (m_cnt == DB) begin
          if (!m_pressed && found) begin
            m_pressed = 1'b1; pend_press = 1'b1; pend_code = code;
          end else if (m_pressed && !found) begin
            m_pressed = 1'b0; pend_release = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  int cyc_tests = 0;
  int cyc_fails = 0;

  task automatic cyc_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cyc_tests++;
    if (act !== exp) begin
      cyc_fails++;
      if (cyc_fails <= 30) $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      cyc_check("o_col", 32'(o_col), 32'(e_col));
      cyc_check("o_key", 32'(o_key), 32'(e_key));
      cyc_check("o_key_valid", 32'(o_key_valid), 32'(e_valid));
      cyc_check("o_key_held", 32'(o_key_held), 32'(e_held));
      cyc_check("o_data", o_data, e_data);
    end
  end

  // Pulse bookkeeping observed from the DUT.
  int         pulses = 0;
  logic [3:0] last_pulse_key = 4'h0;

  always @(negedge clk) begin
    if (m_live && o_key_valid === 1'b1) begin
      pulses++;
      last_pulse_key = o_key;
    end
  end

  // Hand-computed literal checks.
  int lit_tests = 0;
  int lit_fails = 0;

  task automatic lit_check(input string name, input logic [31:0] act, input logic [31:0] exp);
    lit_tests++;
    if (act !== exp) begin
      lit_fails++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_boundary();
    do begin
      @(posedge clk); #1;
    end while (tick % SCAN != 0);
  endtask

  task automatic run_scans(input int n);
    repeat (n) next_boundary();
  endtask

  task automatic check_cleared(input string tag);
    lit_check({tag, "_col"}, 32'(o_col), 32'h0000000E);
    lit_check({tag, "_key"}, 32'(o_key), 32'h0);
    lit_check({tag, "_valid"}, 32'(o_key_valid), 32'h0);
    lit_check({tag, "_held"}, 32'(o_key_held), 32'h0);
    lit_check({tag, "_data"}, o_data, 32'h0);
  endtask

  int p0;
  int tests_total;
  int fails_total;
  logic [3:0] digits [9] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hF, 4'h0, 4'h0, 4'h0, 4'hC};

  initial begin
    // 1. Reset and scan order
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("t1_rst");
    rstn = 1'b1;
    repeat (4) @(posedge clk); #1; lit_check("t1_col4",  32'(o_col), 32'h0000000D);
    repeat (4) @(posedge clk); #1; lit_check("t1_col8",  32'(o_col), 32'h0000000B);
    repeat (4) @(posedge clk); #1; lit_check("t1_col12", 32'(o_col), 32'h00000007);
    repeat (4) @(posedge clk); #1; lit_check("t1_col16", 32'(o_col), 32'h0000000E);
    run_scans(3);

    // 2. Single press and release of key 5
    p0 = pulses;
    keys[5] = 1'b1;
    run_scans(3);
    lit_check("t2_no_pulse_yet", 32'(o_key_valid), 32'h0);
    @(posedge clk); #1;
    lit_check("t2_pulse", 32'(o_key_valid), 32'h1);
    lit_check("t2_key", 32'(o_key), 32'h5);
    lit_check("t2_held", 32'(o_key_held), 32'h1);
    run_scans(17);
    lit_check("t2_one_pulse", 32'(pulses - p0), 32'h1);
    lit_check("t2_data", o_data, 32'h00000005);
    keys[5] = 1'b0;
    run_scans(3);
    lit_check("t2_held_before_release", 32'(o_key_held), 32'h1);
    @(posedge clk); #1;
    lit_check("t2_released", 32'(o_key_held), 32'h0);
    lit_check("t2_key_kept", 32'(o_key), 32'h5);
    run_scans(3);
    lit_check("t2_no_second_pulse", 32'(pulses - p0), 32'h1);

    // 3. Bounce then steady press of key 9, then a short glitch
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      keys[9] = (i % 2 == 0);
      run_scans(1);
    end
    keys[9] = 1'b1;
    run_scans(10);
    lit_check("t3_bounce_pulses", 32'(pulses - p0), 32'h1);
    lit_check("t3_key", 32'(last_pulse_key), 32'h9);
    keys[9] = 1'b0;
    run_scans(5);
    p0 = pulses;
    keys[9] = 1'b1;
    run_scans(2);
    keys[9] = 1'b0;
    run_scans(5);
    lit_check("t3_glitch_no_pulse", 32'(pulses - p0), 32'h0);
    lit_check("t3_glitch_not_held", 32'(o_key_held), 32'h0);

    // 4. Digit history from a clean reset
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 9; i++) begin
      keys[digits[i]] = 1'b1;
      run_scans(5);
      keys[digits[i]] = 1'b0;
      run_scans(5);
      if (i == 3) lit_check("t4_four_digits", o_data, 32'h0000123A);
    end
    lit_check("t4_nine_digits", o_data, 32'h23AF000C);
    lit_check("t4_pulses", 32'(pulses - p0), 32'h9);

    // 5. Two keys together, then roll-over
    p0 = pulses;
    keys[6] = 1'b1; keys[9] = 1'b1;
    run_scans(6);
    lit_check("t5_pair_pulse", 32'(pulses - p0), 32'h1);
    lit_check("t5_lowest", 32'(last_pulse_key), 32'h6);
    keys[6] = 1'b0;
    run_scans(6);
    lit_check("t5_rollover_ignored", 32'(pulses - p0), 32'h1);
    lit_check("t5_still_held", 32'(o_key_held), 32'h1);
    keys[9] = 1'b0;
    run_scans(5);
    lit_check("t5_released", 32'(o_key_held), 32'h0);
    keys[9] = 1'b1;
    run_scans(5);
    lit_check("t5_repress", 32'(pulses - p0), 32'h2);
    lit_check("t5_repress_key", 32'(last_pulse_key), 32'h9);
    keys[9] = 1'b0;
    run_scans(5);

    // 6. Reset while key 5 is held
    keys[5] = 1'b1;
    run_scans(5);
    lit_check("t6_held", 32'(o_key_held), 32'h1);
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    check_cleared("t6_rst");
    @(posedge clk); #1;
    rstn = 1'b1;
    p0 = pulses;
    run_scans(3);
    lit_check("t6_no_early_pulse", 32'(pulses - p0), 32'h0);
    @(posedge clk); #1;
    lit_check("t6_pulse", 32'(o_key_valid), 32'h1);
    lit_check("t6_key", 32'(o_key), 32'h5);
    lit_check("t6_data", o_data, 32'h00000005);
    keys[5] = 1'b0;
    run_scans(5);
    lit_check("t6_release", 32'(o_key_held), 32'h0);

    tests_total = cyc_tests + lit_tests;
    fails_total = cyc_fails + lit_fails;
    $display("[TB] %0d tests run, %0d failed", tests_total, fails_total);
    $finish;
  end

endmodule
